soc2_ram_tester: RTL
====================

// Module: soc2_ram_tester
// PURPOSE
//   Avalon-MM master that drives the SoC2 on-chip RAM slave (512 x 32, byte-enabled) from the initiator side.
//   FILL op writes an incrementing pattern over a word range. VERIFY op reads the range back with pipelined reads,
//   compares each word and reports an error count and the first failing address. It sits beside the CPU
//   as a second master on the RAM's interconnect for power-on self-test and memory bring-up.
// PARAMETERS
//   ADDR_W   11  byte-address width of avm_address (2048 B = 512 words)
//   LEN_W    10  width of len/err_count (max 512 words)
//   MAX_OUT  4   max outstanding reads in VERIFY (1..7)
// PORTS
//   clk               in   1       system clock
//   reset_n           in   1       asynchronous active-low reset
//   start             in   1       1-cycle request; sampled only in IDLE
//   op                in   1       0=FILL, 1=VERIFY; sampled with start
//   base              in   ADDR_W  start byte address, bits[1:0] ignored (forced 0); sampled with start
//   len               in   LEN_W   word count; sampled with start
//   seed              in   32      pattern seed; sampled with start
//   busy              out  1       high from cycle after accepted start until done
//   done              out  1       1-cycle pulse at op completion
//   err_count         out  LEN_W   VERIFY mismatches; cleared on start
//   first_err_valid   out  1       set on first mismatch; cleared on start
//   first_err_addr    out  ADDR_W  byte address of first mismatch; held until next start
//   avm_address       out  ADDR_W  byte address
//   avm_byteenable    out  4       always 4'hF while read/write asserted, else 0
//   avm_read          out  1       read command
//   avm_write         out  1       write command
//   avm_writedata     out  32      write data
//   avm_waitrequest   in   1       slave stall
//   avm_readdata      in   32      read data
//   avm_readdatavalid in   1       read response strobe
// BEHAVIOUR
//   - Reset: every output 0; FSM = IDLE; internal counters 0. Effect is immediate (asynchronous).
//   - FSM: IDLE -> FILL | READ on start; FILL -> DONE after last write accepted;
//     READ -> DRAIN after last read accepted; DRAIN -> DONE when outstanding==0; DONE -> IDLE (done=1 this cycle).
//   - start with len==0: no bus traffic. IDLE -> DONE, so done pulses the cycle after start. busy stays 0.
//   - start outside IDLE is ignored. First command is driven the cycle after start.
//   - Word i (0..len-1): address = base + 4*i mod 2^ADDR_W (wraps). Pattern = seed + i mod 2^32.
//   - Accept = (avm_read|avm_write) & !avm_waitrequest. While waitrequest=1, address/data/command are held stable.
//     Index advances only on accept. Never both read and write in one cycle.
//   - FILL: avm_write held high continuously until the last accept; one write per accepted cycle.
//   - VERIFY: avm_read asserted only while outstanding < MAX_OUT.
//     outstanding +1 on read accept, -1 on readdatavalid; both in the same cycle = unchanged.
//   - Responses arrive in order. Response k is compared with seed+k. On mismatch err_count += 1.
//     On the first mismatch, also set first_err_valid and capture first_err_addr = base + 4*k.
//   - readdatavalid with outstanding==0 or in IDLE/DONE: ignored; no count change.
//   - done timing: 1 cycle after the last write accept (FILL), or 1 cycle after the last readdatavalid (VERIFY).
//     Result outputs are stable when done=1 and stay so until the next start.
//   - Reset mid-operation: bus commands drop immediately. Responses still in flight after reset release are ignored.
// TESTING
//   1. FILL base=0 len=4 seed=0x1000, waitrequest=0 -> writes 0x0/0x4/0x8/0xC data 0x1000..0x1003, be=F;
//      done one cycle after 4th accept.
//   2. Same FILL, waitrequest=1 for 3 cycles on 2nd write -> addr 0x4 / data 0x1001 held; exactly 4 writes total.
//   3. FILL then VERIFY base=0 len=512 seed=0xA5A5_0000 on RAM model with readLatency 1 and random waitrequest
//      -> err_count=0, first_err_valid=0, outstanding never >4.
//   4. VERIFY after corrupting words at 0x010 and 0x020 -> err_count=2, first_err_addr=0x010, first_err_valid=1.
//   5. FILL base=0x7F8 len=4 -> addresses 0x7F8, 0x7FC, 0x000, 0x004. len=0 -> no traffic, done pulse next cycle.
//   6. reset_n low mid-VERIFY with 3 reads outstanding -> all outputs 0 at once. Stray readdatavalid afterwards ignored.
//      Next VERIFY start passes cleanly.

Source files
------------

// File: rtl/soc2_ram_tester.sv
// Avalon-MM self-test master for the SoC2 512x32 RAM: FILL writes seed+i, VERIFY reads back and counts mismatches.
// Latency: first command the cycle after start; done one cycle after the last write accept / last readdatavalid.
// Backpressure: commands held stable under avm_waitrequest; reads throttled to MAX_OUT outstanding.
module soc2_ram_tester #(
  parameter int ADDR_W  = 11,
  parameter int LEN_W   = 10,
  parameter int MAX_OUT = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_byteenable,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_READ  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [2:0] MAX_OUT_C = 3'(MAX_OUT);

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [31:0]       seed_q;
  logic [LEN_W-1:0]  cmd_idx;
  logic [LEN_W-1:0]  rsp_idx;
  logic [2:0]        outstanding, outstanding_nxt;

  logic              start_go;
  logic              wr_cmd, rd_cmd;
  logic              cmd_acc, rd_acc;
  logic              last_cmd;
  logic              rsp_ok, rsp_bad;
  logic [ADDR_W-1:0] cmd_addr, rsp_addr;
  logic [31:0]       cmd_data, exp_data;

  assign start_go = (state == S_IDLE) && start;

  // Word index to byte address wraps naturally at the ADDR_W boundary.
  assign cmd_addr = base_q + ADDR_W'({cmd_idx, 2'b00});
  assign rsp_addr = base_q + ADDR_W'({rsp_idx, 2'b00});
  assign cmd_data = seed_q + 32'(cmd_idx);
  assign exp_data = seed_q + 32'(rsp_idx);

  assign wr_cmd   = (state == S_FILL);
  assign rd_cmd   = (state == S_READ) && (outstanding < MAX_OUT_C);
  assign cmd_acc  = (wr_cmd || rd_cmd) && !avm_waitrequest;
  assign rd_acc   = rd_cmd && !avm_waitrequest;
  assign last_cmd = (cmd_idx == len_q - LEN_W'(1));

  // Responses only count while a read is actually owed; strays are dropped.
  assign rsp_ok  = avm_readdatavalid && ((state == S_READ) || (state == S_DRAIN)) && (outstanding != 3'd0);
  assign rsp_bad = rsp_ok && (avm_readdata != exp_data);

  // Bus outputs are pure decodes of state so reset clears them immediately.
  assign avm_write      = wr_cmd;
  assign avm_read       = rd_cmd;
  assign avm_address    = (wr_cmd || rd_cmd) ? cmd_addr : '0;
  assign avm_byteenable = (wr_cmd || rd_cmd) ? 4'hF : 4'h0;
  assign avm_writedata  = wr_cmd ? cmd_data : 32'h0;
  assign busy           = (state == S_FILL) || (state == S_READ) || (state == S_DRAIN);
  assign done           = (state == S_DONE);

  // Outstanding read tracker: simultaneous accept and response cancel out.
  always_comb begin
    outstanding_nxt = outstanding;
    if (rd_acc && !rsp_ok) begin
      outstanding_nxt = outstanding + 3'd1;
    end else if (!rd_acc && rsp_ok) begin
      outstanding_nxt = outstanding - 3'd1;
    end
  end

  // Next-state decode; DRAIN looks at the post-update count so done lands one cycle after the last response.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (len == '0) state_nxt = S_DONE;
          else           state_nxt = op ? S_READ : S_FILL;
        end
      end
      S_FILL:  if (cmd_acc && last_cmd) state_nxt = S_DONE;
      S_READ:  if (rd_acc && last_cmd)  state_nxt = S_DRAIN;
      S_DRAIN: if (outstanding_nxt == 3'd0) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Operation parameters captured on an accepted start; low address bits are forced to word alignment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q <= '0;
      len_q  <= '0;
      seed_q <= '0;
    end else if (start_go) begin
      base_q <= base & ~ADDR_W'(3);
      len_q  <= len;
      seed_q <= seed;
    end
  end

  // Command/response indices and outstanding count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_idx     <= '0;
      rsp_idx     <= '0;
      outstanding <= '0;
    end else if (start_go) begin
      cmd_idx     <= '0;
      rsp_idx     <= '0;
      outstanding <= '0;
    end else begin
      if (cmd_acc) cmd_idx <= cmd_idx + LEN_W'(1);
      if (rsp_ok)  rsp_idx <= rsp_idx + LEN_W'(1);
      outstanding <= outstanding_nxt;
    end
  end

  // Result registers: cleared on start, updated per mismatching response, first failing address latched once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (start_go) begin
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
    end else if (rsp_bad) begin
      err_count <= err_count + LEN_W'(1);
      if (!first_err_valid) begin
        first_err_valid <= 1'b1;
        first_err_addr  <= rsp_addr;
      end
    end
  end

endmodule
